// File: rtl/fifo_reader_if.sv
// fifo_reader_if: FIFO read-port control plus the valid/ready word stream.
interface fifo_reader_if #(parameter int WIDTH = 4);
   logic             fifo_en;
   logic             fifo_rd;
   logic             fifo_wr;
   logic             fifo_status;
   logic [WIDTH-1:0] fifo_data;
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_ready;
   modport master (
      output fifo_en, fifo_rd, fifo_wr, fifo_status, m_data, m_valid,
      input  fifo_data, m_ready
   );
   modport slave (
      input  fifo_en, fifo_rd, fifo_wr, fifo_status, m_data, m_valid,
      output fifo_data, m_ready
   );
endinterface

// File: rtl/fifo_reader.sv
// fifo_reader: polls fifo_memory status, pulls one word per transaction and
// presents it on a valid/ready stream, hiding the FIFO's muxed registered output.
module fifo_reader #(
   parameter int WIDTH    = 4,
   parameter int POLL_GAP = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          run,
   fifo_reader_if.master bus,
   output logic [3:0]    flags,
   output logic          busy,
   output logic [7:0]    words_read
);
   typedef enum logic [2:0] {S_IDLE, S_POLL, S_EVAL, S_READ, S_FETCH, S_CAPTURE, S_HOLD} state_t;
   localparam logic [3:0] GAP_INIT = 4'(POLL_GAP - 1);
   state_t           state, state_nx;
   logic [3:0]       gap, gap_nx;
   logic [WIDTH-1:0] m_data_q;
   logic             m_valid_q, en, rd, status;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state      <= S_IDLE;
         gap        <= '0;
         flags      <= '0;
         m_data_q   <= '0;
         m_valid_q  <= 1'b0;
         words_read <= '0;
      end else begin
         state <= state_nx;
         gap   <= gap_nx;
         if (state == S_EVAL) flags <= bus.fifo_data[3:0];
         if (state == S_CAPTURE) begin
            m_data_q   <= bus.fifo_data;
            m_valid_q  <= 1'b1;
            words_read <= words_read + 8'd1;
         end else if (state == S_HOLD && bus.m_ready) m_valid_q <= 1'b0;
      end
   always_comb begin
      state_nx = state;
      gap_nx   = gap;
      en       = 1'b0;
      rd       = 1'b0;
      status   = 1'b0;
      unique case (state)
         S_IDLE: if (run) begin
            state_nx = S_POLL;
            gap_nx   = GAP_INIT;
         end
         S_POLL: begin
            en       = 1'b1;
            state_nx = (gap == 4'd0) ? S_EVAL : S_POLL;
            gap_nx   = (gap == 4'd0) ? gap : gap - 4'd1;
         end
         S_EVAL: begin
            en       = 1'b1;
            state_nx = !run ? S_IDLE : bus.fifo_data[1] ? S_POLL : S_READ;
            gap_nx   = GAP_INIT;
         end
         S_READ: begin
            en       = 1'b1;
            rd       = 1'b1;
            status   = 1'b1;
            state_nx = S_FETCH;
         end
         S_FETCH: begin
            en       = 1'b1;
            status   = 1'b1;
            state_nx = S_CAPTURE;
         end
         S_CAPTURE: begin
            en       = 1'b1;
            status   = 1'b1;
            state_nx = S_HOLD;
         end
         // FIFO frozen until the consumer takes the word
         S_HOLD: begin
            status = 1'b1;
            if (bus.m_ready) begin
               state_nx = run ? S_POLL : S_IDLE;
               gap_nx   = GAP_INIT;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end
   assign bus.fifo_en     = en;
   assign bus.fifo_rd     = rd;
   assign bus.fifo_wr     = 1'b0;
   assign bus.fifo_status = status;
   assign bus.m_data      = m_data_q;
   assign bus.m_valid     = m_valid_q;
   assign busy            = (state != S_IDLE);
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed checks of fifo_reader against a behavioural fifo_memory model.
module tb_fifo_reader;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       run = 1'b0;
   logic [3:0] flags;
   logic       busy;
   logic [7:0] words_read;
   int         checks = 0;
   int         fails = 0;
   int         rd_cnt = 0;
   logic       prev_rd = 1'b0;
   logic [3:0] fq[$];
   logic [3:0] dreg = '0;
   logic [3:0] dout = '0;
   int         n;

   fifo_reader_if #(.WIDTH(4)) bus ();

   fifo_reader #(.WIDTH(4), .POLL_GAP(3)) dut (
      .clk(clk), .reset(reset), .run(run), .bus(bus),
      .flags(flags), .busy(busy), .words_read(words_read)
   );

   always #5 clk = ~clk;

   assign bus.fifo_data = dout;

   // FIFO model: registered output muxed by status, frozen while EN is low
   always @(posedge clk)
      if (bus.fifo_en) begin
         n = fq.size();
         dout <= bus.fifo_status ? dreg : {n == 8, n >= 4, n == 0, !bus.fifo_rd};
         if (bus.fifo_rd && n > 0) dreg <= fq.pop_front();
      end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.fifo_rd) begin
         rd_cnt++;
         chk("rd_single_cycle", {31'd0, prev_rd}, 32'd0);
      end
      prev_rd = bus.fifo_rd;
   end

   task automatic do_reset();
      reset = 1'b0;
      run = 1'b0;
      bus.m_ready = 1'b0;
      fq.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_next(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bus.m_valid && cyc < 100);
   endtask

   task automatic wait_rd();
      for (int c = 0; c < 100 && !bus.fifo_rd; c++) @(negedge clk);
      chk("rd_seen", {31'd0, bus.fifo_rd}, 32'd1);
   endtask

   typedef struct {
      int         n;
      logic [3:0] base;
      logic [3:0] exp_flags;
      int         exp_lat;
   } vec_t;

   vec_t vt[4];
   int   cyc, base_rd, bad, got;

   initial begin
      vt[0] = '{1, 4'hA, 4'h1, 8};
      vt[1] = '{2, 4'h6, 4'h1, 8};
      vt[2] = '{4, 4'hC, 4'h5, 8};
      vt[3] = '{7, 4'h2, 4'h5, 8};
      bus.m_ready = 1'b0;
      #2;
      chk("rst_en", {31'd0, bus.fifo_en}, 0);
      chk("rst_rd", {31'd0, bus.fifo_rd}, 0);
      chk("rst_wr", {31'd0, bus.fifo_wr}, 0);
      chk("rst_status", {31'd0, bus.fifo_status}, 0);
      chk("rst_mdata", {28'd0, bus.m_data}, 0);
      chk("rst_mvalid", {31'd0, bus.m_valid}, 0);
      chk("rst_flags", {28'd0, flags}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_words", {24'd0, words_read}, 0);

      for (int v = 0; v < 4; v++) begin
         do_reset();
         for (int i = 0; i < vt[v].n; i++) fq.push_back(vt[v].base + 4'(i));
         bus.m_ready = 1'b1;
         run = 1'b1;
         wait_next(cyc);
         chk($sformatf("vec%0d_latency", v), cyc, vt[v].exp_lat);
         chk($sformatf("vec%0d_data", v), {28'd0, bus.m_data}, {28'd0, vt[v].base});
         chk($sformatf("vec%0d_flags", v), {28'd0, flags}, {28'd0, vt[v].exp_flags});
         chk($sformatf("vec%0d_words", v), {24'd0, words_read}, 1);
      end

      do_reset();
      base_rd = rd_cnt;
      run = 1'b1;
      repeat (40) @(negedge clk);
      chk("empty_no_rd", rd_cnt - base_rd, 0);
      chk("empty_flags", {28'd0, flags}, 4'h3);
      chk("empty_mvalid", {31'd0, bus.m_valid}, 0);
      chk("empty_busy", {31'd0, busy}, 1);

      do_reset();
      base_rd = rd_cnt;
      for (int i = 1; i <= 8; i++) fq.push_back(4'(i));
      bus.m_ready = 1'b1;
      run = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         wait_next(cyc);
         chk($sformatf("burst%0d_spacing", k), cyc, 8);
         if (k == 1) chk("burst_full_flags", {28'd0, flags}, 4'hD);
         chk($sformatf("burst%0d_data", k), {28'd0, bus.m_data}, k);
      end
      repeat (40) @(negedge clk);
      chk("burst_rd_count", rd_cnt - base_rd, 8);
      chk("burst_empty_flags", {28'd0, flags}, 4'h3);
      chk("burst_words", {24'd0, words_read}, 8);

      do_reset();
      fq.push_back(4'h5);
      fq.push_back(4'h3);
      run = 1'b1;
      wait_next(cyc);
      chk("bp_first_data", {28'd0, bus.m_data}, 4'h5);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.m_data !== 4'h5 || bus.m_valid !== 1'b1 || bus.fifo_en !== 1'b0) bad++;
      end
      chk("bp_hold_stable", bad, 0);
      bus.m_ready = 1'b1;
      wait_next(cyc);
      chk("bp_second_data", {28'd0, bus.m_data}, 4'h3);
      chk("bp_words", {24'd0, words_read}, 2);

      do_reset();
      base_rd = rd_cnt;
      fq.push_back(4'h7);
      fq.push_back(4'h9);
      bus.m_ready = 1'b1;
      run = 1'b1;
      @(negedge clk);
      wait_rd();
      run = 1'b0;
      wait_next(cyc);
      chk("drop_data", {28'd0, bus.m_data}, 4'h7);
      repeat (30) @(negedge clk);
      chk("drop_rd_count", rd_cnt - base_rd, 1);
      chk("drop_busy", {31'd0, busy}, 0);
      chk("drop_words", {24'd0, words_read}, 1);
      chk("drop_mvalid", {31'd0, bus.m_valid}, 0);

      do_reset();
      fq.push_back(4'hA);
      fq.push_back(4'hB);
      bus.m_ready = 1'b1;
      run = 1'b1;
      wait_next(cyc);
      @(negedge clk);
      wait_rd();
      @(negedge clk);
      chk("fetch_status", {31'd0, bus.fifo_status}, 1);
      reset = 1'b0;
      #1;
      chk("arst_en", {31'd0, bus.fifo_en}, 0);
      chk("arst_status", {31'd0, bus.fifo_status}, 0);
      chk("arst_mdata", {28'd0, bus.m_data}, 0);
      chk("arst_mvalid", {31'd0, bus.m_valid}, 0);
      chk("arst_flags", {28'd0, flags}, 0);
      chk("arst_busy", {31'd0, busy}, 0);
      chk("arst_words", {24'd0, words_read}, 0);
      run = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("release_busy", {31'd0, busy}, 0);
      chk("release_wr", {31'd0, bus.fifo_wr}, 0);

      do_reset();
      bus.m_ready = 1'b1;
      run = 1'b1;
      got = 0;
      for (int c = 0; c < 4000 && got < 256; c++) begin
         @(negedge clk);
         if (fq.size() < 3) fq.push_back(4'(c));
         if (bus.m_valid) begin
            got++;
            if (got == 255) chk("wrap_255", {24'd0, words_read}, 255);
         end
      end
      chk("wrap_count", got, 256);
      chk("wrap_words", {24'd0, words_read}, 0);
      run = 1'b0;
      repeat (20) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
